// File: rtl/fetch_pc_select.sv
// fetch_pc_select: Y86-64 fetch PC mux, predicted-PC register and ret/halt fetch-blocking FSM.
// Define BTFNT_PRED_EN for backward-taken/forward-not-taken jXX prediction with two-way correction.
module fetch_pc_select #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic [3:0]       f_icode,
    input  logic [WIDTH-1:0] f_valc,
    input  logic [WIDTH-1:0] f_valp,
    input  logic [3:0]       m_icode,
    input  logic             m_cnd,
    input  logic [WIDTH-1:0] m_vala,
`ifdef BTFNT_PRED_EN
    input  logic             m_pred_nt,
    input  logic [WIDTH-1:0] m_valc,
    output logic             f_pred_nt,
`endif
    input  logic [3:0]       w_icode,
    input  logic [WIDTH-1:0] w_valm,
    output logic [WIDTH-1:0] f_pc,
    output logic [WIDTH-1:0] pred_pc,
    output logic             f_bubble,
    output logic             flush_de,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] ret_wait_cnt
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_RET_WAIT = 2'd1, S_HALTED = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pred_pc;
    logic [WIDTH-1:0] w_pred_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mis_nt;
    logic             w_mis_t;
    logic             w_mispredict;
    logic             w_ret_arrive;
    logic             w_fetch_ok;
    logic             w_jxx_taken;

    always_comb begin
        w_mis_nt     = (m_icode == 4'h7) && !m_cnd;
`ifdef BTFNT_PRED_EN
        w_mis_t      = (m_icode == 4'h7) && m_cnd && m_pred_nt;
        w_jxx_taken  = f_valc < f_valp;
        f_pred_nt    = (f_icode == 4'h7) && !w_jxx_taken;
        f_pc         = w_mis_nt ? m_vala : w_mis_t ? m_valc : (w_icode == 4'h9) ? w_valm : r_pred_pc;
`else
        w_mis_t      = 1'b0;
        w_jxx_taken  = 1'b1;
        f_pc         = w_mis_nt ? m_vala : (w_icode == 4'h9) ? w_valm : r_pred_pc;
`endif
        w_mispredict = w_mis_nt || w_mis_t;
        w_ret_arrive = (r_state == S_RET_WAIT) && (w_icode == 4'h9);
        // A mispredict redirects onto the correct path, so nothing fetched there is bubbled.
        f_bubble     = !w_mispredict && (((r_state == S_RET_WAIT) && (w_icode != 4'h9)) || (r_state == S_HALTED));
        flush_de     = w_mispredict;
        w_fetch_ok   = !stall_f && (r_state == S_RUN);
        w_pred_nxt   = (((f_icode == 4'h7) && w_jxx_taken) || (f_icode == 4'h8)) ? f_valc : f_valp;
        w_state_nxt  = (w_mispredict || w_ret_arrive) ? S_RUN :
                       (w_fetch_ok && (f_icode == 4'h9)) ? S_RET_WAIT :
                       (w_fetch_ok && (f_icode == 4'h0)) ? S_HALTED : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_pred_pc <= RESET_PC;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!stall_f && !f_bubble)
                r_pred_pc <= w_pred_nxt;
            if (r_state != S_RET_WAIT && w_state_nxt == S_RET_WAIT)
                r_cnt <= '0;
            else if (r_state == S_RET_WAIT && w_state_nxt == S_RET_WAIT && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign pred_pc      = r_pred_pc;
    assign fsm_state    = r_state;
    assign ret_wait_cnt = r_cnt;
endmodule

// File: tb/tb_fetch_pc_select.sv
// tb_fetch_pc_select: directed test-plan scenarios plus random traffic against a behavioural model.
module tb_fetch_pc_select;
    logic        clk = 0;
    logic        rst, stall_f, m_cnd;
    logic [3:0]  f_icode, m_icode, w_icode;
    logic [63:0] f_valc, f_valp, m_vala, w_valm;
    logic [63:0] f_pc, pred_pc;
    logic        f_bubble, flush_de;
    logic [1:0]  fsm_state;
    logic [7:0]  ret_wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural state as plain integers.
    logic [63:0] md_pred;
    int          md_state;
    int          md_cnt;

    fetch_pc_select dut (
        .clk(clk), .rst(rst), .stall_f(stall_f),
        .f_icode(f_icode), .f_valc(f_valc), .f_valp(f_valp),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_vala(m_vala),
        .w_icode(w_icode), .w_valm(w_valm),
        .f_pc(f_pc), .pred_pc(pred_pc), .f_bubble(f_bubble), .flush_de(flush_de),
        .fsm_state(fsm_state), .ret_wait_cnt(ret_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit mis();
        return m_icode == 4'h7 && !m_cnd;
    endfunction

    function automatic bit exp_bubble();
        if (mis()) return 1'b0;
        if (md_state == 1) return w_icode != 4'h9;
        return md_state == 2;
    endfunction

    // Check every output against the model, then clock and advance the model.
    task automatic cyc();
        logic [63:0] exp_pc;
        bit          bub;
        int          old;
        #1;
        exp_pc = mis() ? m_vala : (w_icode == 4'h9) ? w_valm : md_pred;
        bub    = exp_bubble();
        check("f_pc", f_pc, exp_pc);
        check("f_bubble", 64'(f_bubble), 64'(bub));
        check("flush_de", 64'(flush_de), 64'(mis()));
        check("pred_pc", pred_pc, md_pred);
        check("fsm_state", 64'(fsm_state), 64'(md_state));
        check("ret_wait_cnt", 64'(ret_wait_cnt), 64'(md_cnt));
        @(posedge clk);
        if (rst) begin
            md_pred = 64'h0; md_state = 0; md_cnt = 0;
        end else begin
            old = md_state;
            if (!stall_f && !bub)
                md_pred = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valc : f_valp;
            if (mis()) md_state = 0;
            else if (md_state == 1 && w_icode == 4'h9) md_state = 0;
            else if (md_state == 0 && !stall_f && f_icode == 4'h9) md_state = 1;
            else if (md_state == 0 && !stall_f && f_icode == 4'h0) md_state = 2;
            if (old != 1 && md_state == 1) md_cnt = 0;
            else if (old == 1 && md_state == 1 && md_cnt < 255) md_cnt++;
        end
        #1;
    endtask

    task automatic idle();
        stall_f = 0; f_icode = 4'h1; m_icode = 4'h1; m_cnd = 1; w_icode = 4'h1;
        f_valc = 0; m_vala = 0; w_valm = 0;
    endtask

    initial begin
        md_pred = 0; md_state = 0; md_cnt = 0;
        idle(); f_valp = 64'h1; rst = 1;
        cyc(); cyc();
        rst = 0;
        #1 check("rel_f_pc", f_pc, 64'h0);
        cyc();
        check("rel_pred_pc", pred_pc, 64'h1);
        check("rel_state", 64'(fsm_state), 64'h0);
        // Mispredicted jXX corrected from M
        f_icode = 4'h7; f_valc = 64'h40; f_valp = 64'h19; cyc();
        f_icode = 4'h1; f_valp = 64'h4a; cyc();
        f_valp = 64'h4b; cyc();
        m_icode = 4'h7; m_cnd = 0; m_vala = 64'h19; f_valp = 64'h1a;
        #1 check("mis_f_pc", f_pc, 64'h19);
        check("mis_flush", 64'(flush_de), 64'h1);
        cyc();
        check("mis_pred", pred_pc, 64'h1a);
        idle();
        // ret waits for W
        f_icode = 4'h9; f_valp = 64'h1b; cyc();
        f_icode = 4'h1; f_valp = 64'h1c;
        check("ret_state", 64'(fsm_state), 64'h1);
        repeat (3) cyc();
        check("ret_frozen", pred_pc, 64'h1b);
        w_icode = 4'h9; w_valm = 64'h200; f_valp = 64'h20a;
        #1 check("ret_f_pc", f_pc, 64'h200);
        check("ret_bubble", 64'(f_bubble), 64'h0);
        cyc();
        check("ret_state_run", 64'(fsm_state), 64'h0);
        check("ret_cnt", 64'(ret_wait_cnt), 64'h3);
        idle();
        // halt, left by mispredict
        f_icode = 4'h0; f_valp = 64'h20b; cyc();
        f_icode = 4'h1;
        repeat (4) cyc();
        check("halt_state", 64'(fsm_state), 64'h2);
        m_icode = 4'h7; m_cnd = 0; m_vala = 64'h80; f_valp = 64'h81;
        #1 check("halt_f_pc", f_pc, 64'h80);
        cyc();
        check("halt_exit", 64'(fsm_state), 64'h0);
        idle();
        // stall holds pred_pc
        stall_f = 1; f_icode = 4'h8; f_valc = 64'h300; f_valp = 64'h8a;
        cyc(); cyc();
        check("stall_hold", pred_pc, 64'h81);
        stall_f = 0; cyc();
        check("stall_rel", pred_pc, 64'h300);
        idle();
        // mispredict beats W ret in RET_WAIT
        f_icode = 4'h9; f_valp = 64'h301; cyc();
        f_icode = 4'h1; cyc();
        m_icode = 4'h7; m_cnd = 0; m_vala = 64'h50; w_icode = 4'h9; w_valm = 64'h90;
        #1 check("both_f_pc", f_pc, 64'h50);
        cyc();
        check("both_state", 64'(fsm_state), 64'h0);
        idle();
        // reset mid RET_WAIT
        f_icode = 4'h9; f_valp = 64'h55; cyc();
        f_icode = 4'h1; cyc();
        rst = 1; cyc();
        check("rst_pred", pred_pc, 64'h0);
        check("rst_state", 64'(fsm_state), 64'h0);
        rst = 0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            stall_f = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 9))
                0:       f_icode = 4'h9;
                1:       f_icode = 4'h0;
                2, 3:    f_icode = 4'h7;
                4:       f_icode = 4'h8;
                default: f_icode = 4'($urandom_range(0, 11));
            endcase
            f_valc  = {$urandom, $urandom};
            f_valp  = {$urandom, $urandom};
            m_icode = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'($urandom_range(0, 11));
            m_cnd   = ($urandom_range(0, 2) != 0);
            m_vala  = {$urandom, $urandom};
            w_icode = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
            w_valm  = {$urandom, $urandom};
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
